// File: rtl/scandoubler_ctrl_if.sv
// Bus bundle between the scandoubler controller and its line buffer / video output stage.
// The master modport is the controller side; slave is the consumer side.
interface scandoubler_ctrl_if;
    logic       csync;
    logic       scanlines;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [9:0] rd_addr;
    logic       hs_out;
    logic       vs_out;
    logic       de_out;
    logic       scan_dark;
    logic [9:0] line_cnt;
    logic       locked;

    modport master (
        input  csync, scanlines,
        output wr_en, wr_addr, rd_addr, hs_out, vs_out, de_out, scan_dark, line_cnt, locked
    );

    modport slave (
        output csync, scanlines,
        input  wr_en, wr_addr, rd_addr, hs_out, vs_out, de_out, scan_dark, line_cnt, locked
    );
endinterface

// File: rtl/scandoubler_ctrl.sv
// Scandoubler timing controller: composite-sync decode, line-buffer addressing, doubled timing.
// Define SCANDOUBLER_SCANLINES_EN to enable the scanline flop and scan_dark output.
module scandoubler_ctrl #(
    parameter int unsigned LINE_LEN  = 414,
    parameter int unsigned VSYNC_THR = 90,
    parameter int unsigned HDE_START = 64,
    parameter int unsigned HDE_END   = 364,
    parameter int unsigned VDE_START = 16,
    parameter int unsigned VDE_END   = 296,
    parameter int unsigned HS_START  = 384
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ce_2pix,
    scandoubler_ctrl_if.master        bus
);

    localparam logic [8:0] SdLast   = 9'(LINE_LEN - 1);
    localparam logic [7:0] VsThr    = 8'(VSYNC_THR);
    localparam logic [8:0] HdeStart = 9'(HDE_START);
    localparam logic [8:0] HdeEnd   = 9'(HDE_END);
    localparam logic [9:0] VdeStart = 10'(VDE_START);
    localparam logic [9:0] VdeEnd   = 10'(VDE_END);
    localparam logic [8:0] HsStart  = 9'(HS_START);

    typedef enum logic [1:0] {StActive, StSync, StVsync} state_e;

    state_e     state_q, state_d;
    logic [7:0] sync_len_q, sync_len_d;
    logic       csync_prev_q;
    logic [8:0] sd_col_q;
    logic [9:0] zx_col_q;
    logic [9:0] line_cnt_q;
    logic       bank_q;
    logic       hs_q, vs_q, de_q, locked_q;
    logic       rise, line_end, sd_clr, vs_enter, h_de, v_de;

    always_comb begin
        rise       = bus.csync & ~csync_prev_q & (state_q != StActive);
        line_end   = rise & (state_q == StSync);
        sd_clr     = line_end | (sd_col_q == SdLast);
        vs_enter   = (state_q == StSync) & ~bus.csync & (sync_len_q == VsThr);
        h_de       = (sd_col_q >= HdeStart) & (sd_col_q < HdeEnd);
        v_de       = (line_cnt_q >= VdeStart) & (line_cnt_q < VdeEnd);
        sync_len_d = bus.csync ? 8'd0 : ((sync_len_q == 8'hff) ? 8'hff : sync_len_q + 8'd1);
        state_d    = state_q;
        unique case (state_q)
            StActive: if (!bus.csync) state_d = StSync;
            StSync:   if (bus.csync) state_d = StActive;
                      else if (sync_len_q == VsThr) state_d = StVsync;
            StVsync:  if (bus.csync) state_d = StActive;
            default:  state_d = StActive;
        endcase
    end

`ifdef SCANDOUBLER_SCANLINES_EN
    logic scanline_q, scan_dark_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StActive;
            sync_len_q   <= '0;
            csync_prev_q <= 1'b1;
            sd_col_q     <= '0;
            zx_col_q     <= '0;
            line_cnt_q   <= '0;
            bank_q       <= 1'b0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            de_q         <= 1'b0;
            locked_q     <= 1'b0;
`ifdef SCANDOUBLER_SCANLINES_EN
            scanline_q   <= 1'b0;
            scan_dark_q  <= 1'b0;
`endif
        end else if (ce_2pix) begin
            state_q      <= state_d;
            sync_len_q   <= sync_len_d;
            csync_prev_q <= bus.csync;
            sd_col_q     <= sd_clr ? 9'd0 : sd_col_q + 9'd1;
            zx_col_q     <= line_end ? 10'd0 : zx_col_q + 10'd1;
            if (rise) bank_q <= ~bank_q;

            // A vsync entry and a rising edge cannot share a tick (csync differs).
            if (vs_enter)  line_cnt_q <= '0;
            else if (rise) line_cnt_q <= line_cnt_q + 10'd1;

            if (vs_enter)       vs_q <= 1'b1;
            else if (bus.csync) vs_q <= 1'b0;

            hs_q <= (sd_col_q >= HsStart);
            de_q <= h_de & v_de;

            if (vs_enter)                   locked_q <= (line_cnt_q[9:8] != 2'b00);
            else if (sync_len_d == 8'hff)   locked_q <= 1'b0;
`ifdef SCANDOUBLER_SCANLINES_EN
            if (vs_enter)    scanline_q <= 1'b0;
            else if (sd_clr) scanline_q <= ~scanline_q;
            scan_dark_q <= bus.scanlines & scanline_q;
`endif
        end
    end

    assign bus.wr_en    = ce_2pix & zx_col_q[0];
    assign bus.wr_addr  = {bank_q, zx_col_q[9:1]};
    assign bus.rd_addr  = {~bank_q, sd_col_q};
    assign bus.hs_out   = hs_q;
    assign bus.vs_out   = vs_q;
    assign bus.de_out   = de_q;
    assign bus.line_cnt = line_cnt_q;
    assign bus.locked   = locked_q;
`ifdef SCANDOUBLER_SCANLINES_EN
    assign bus.scan_dark = scan_dark_q;
`else
    assign bus.scan_dark = 1'b0;
`endif

endmodule
